// File: rtl/fpu_sub_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 subtract datapath among NREQ requesters.
// One op in flight; response appears DP_LATENCY cycles after accept and is held until resp_ready.
module fpu_sub_arbiter #(
  parameter int NREQ       = 2,
  parameter int WIDTH      = 32,
  parameter int DP_LATENCY = 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [WIDTH-1:0]          resp_result,
  output logic                      resp_overflow,
  output logic                      resp_underflow,
  output logic [WIDTH-1:0]          dp_data1,
  output logic [WIDTH-1:0]          dp_data2,
  input  logic [WIDTH-1:0]          dp_result,
  input  logic                      dp_overflow,
  input  logic                      dp_underflow
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = ($clog2(DP_LATENCY + 1) < 1) ? 1 : $clog2(DP_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;
  logic [CW-1:0]    cnt;
  logic             accept, sample, done;
  logic [WIDTH-1:0] gnt_a, gnt_b;

  // Search upward from rr_ptr, wrapping, for the first valid requester.
  always_comb begin : grant_search
    int             sum;
    logic [IDW-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = 0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_a = req_a[gnt_idx*WIDTH +: WIDTH];
  // Add becomes subtract of the negated operand B.
  assign gnt_b = req_b[gnt_idx*WIDTH +: WIDTH] ^ {req_op[gnt_idx], {(WIDTH-1){1'b0}}};

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (gnt_found) begin
        accept     = 1'b1;
        state_next = EXEC;
      end
      EXEC: if (cnt == '0) begin
        sample     = 1'b1;
        state_next = RESP;
      end
      RESP: if (resp_ready) begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr_ptr         <= '0;
      cnt            <= '0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_result    <= '0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
      dp_data1       <= '0;
      dp_data2       <= '0;
    end else begin
      if (accept) begin
        dp_data1 <= gnt_a;
        dp_data2 <= gnt_b;
        resp_id  <= gnt_idx;
        rr_ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        cnt      <= CW'(DP_LATENCY - 1);
      end
      if (state == EXEC && cnt != '0) cnt <= cnt - 1'b1;
      if (sample) begin
        resp_result    <= dp_result;
        resp_overflow  <= dp_overflow;
        resp_underflow <= dp_underflow;
        resp_valid     <= 1'b1;
      end
      if (done) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_sub_arbiter.sv
// Bench for fpu_sub_arbiter: two instances (DP_LATENCY 1 and 3), real-valued FP32 subtract datapath
// model, directed scenarios then random traffic checked cycle by cycle against a transaction-level model.
module tb_fpu_sub_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST;
  logic [1:0]  req_valid [2];
  logic [1:0]  req_ready [2];
  logic [1:0]  req_op    [2];
  logic [63:0] req_a     [2];
  logic [63:0] req_b     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic        resp_id    [2];
  logic [31:0] resp_result [2];
  logic        resp_overflow [2];
  logic        resp_underflow [2];
  logic [31:0] dp_data1 [2];
  logic [31:0] dp_data2 [2];
  logic [31:0] dp_result [2];
  logic        dp_overflow [2];
  logic        dp_underflow [2];
  logic        inj [2];

  fpu_sub_arbiter #(.NREQ(2), .WIDTH(32), .DP_LATENCY(1)) dut1 (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_id(resp_id[0]),
    .resp_result(resp_result[0]), .resp_overflow(resp_overflow[0]), .resp_underflow(resp_underflow[0]),
    .dp_data1(dp_data1[0]), .dp_data2(dp_data2[0]),
    .dp_result(dp_result[0]), .dp_overflow(dp_overflow[0]), .dp_underflow(dp_underflow[0])
  );

  fpu_sub_arbiter #(.NREQ(2), .WIDTH(32), .DP_LATENCY(3)) dut3 (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_id(resp_id[1]),
    .resp_result(resp_result[1]), .resp_overflow(resp_overflow[1]), .resp_underflow(resp_underflow[1]),
    .dp_data1(dp_data1[1]), .dp_data2(dp_data2[1]),
    .dp_result(dp_result[1]), .dp_overflow(dp_overflow[1]), .dp_underflow(dp_underflow[1])
  );

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] ex;
    if (x[30:0] == 31'd0) return $bitstoreal({x[31], 63'd0});
    ex = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], ex, x[22:0], 29'd0});
  endfunction

  // Returns {overflow, underflow, result}; result mantissa is truncated.
  function automatic logic [33:0] fp_sub(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] d;
    int          e, se;
    logic [33:0] r;
    d = $realtobits(f2r(x) - f2r(y));
    e = int'(d[62:52]);
    if (e == 0) r = {2'b00, d[63], 31'd0};
    else begin
      se = e - 896;
      if (se >= 255)   r = {2'b10, d[63], 8'hFF, 23'd0};
      else if (se <= 0) r = {2'b01, d[63], 31'd0};
      else             r = {2'b00, d[63], se[7:0], d[51:29]};
    end
    return r;
  endfunction

  always_comb begin
    {dp_overflow[0], dp_underflow[0], dp_result[0]} = fp_sub(dp_data1[0], dp_data2[0]);
    dp_overflow[0] = dp_overflow[0] | inj[0];
    {dp_overflow[1], dp_underflow[1], dp_result[1]} = fp_sub(dp_data1[1], dp_data2[1]);
    dp_overflow[1] = dp_overflow[1] | inj[1];
  end

  int          checks = 0, errors = 0, cyc = 0;
  int          m_ptr [2], m_wait [2], m_id [2], acc_id [2];
  bit          m_busy [2], m_rv [2], acc [2];
  logic [31:0] m_res [2], m_d1 [2], m_d2 [2];
  logic        m_ovf [2], m_unf [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_ptr[d] = 0; m_wait[d] = 0; m_id[d] = 0; m_busy[d] = 0; m_rv[d] = 0;
    m_res[d] = 0; m_d1[d] = 0; m_d2[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
  endtask

  // One clock: compare every output with the model, then advance model across the edge.
  task automatic step();
    int          g [2];
    bit          fnd [2];
    logic [1:0]  ex_rdy;
    logic        rst_pre;
    logic        rr_pre [2];
    logic        inj_pre [2];
    logic [1:0]  op_pre [2];
    logic [63:0] a_pre [2];
    logic [63:0] b_pre [2];
    logic [31:0] bb;
    logic [33:0] r;
    int          lat;
    #1;
    rst_pre = nRST;
    for (int d = 0; d < 2; d++) begin
      fnd[d] = 0; g[d] = 0;
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (m_ptr[d] + k) % 2;
        if (!fnd[d] && req_valid[d][idx]) begin fnd[d] = 1; g[d] = idx; end
      end
      ex_rdy = (!m_busy[d] && fnd[d]) ? (2'b01 << g[d]) : 2'b00;
      chk($sformatf("d%0d_req_ready", d), req_ready[d], ex_rdy);
      chk($sformatf("d%0d_resp_valid", d), resp_valid[d], m_rv[d]);
      chk($sformatf("d%0d_resp_id", d), resp_id[d], m_id[d]);
      chk($sformatf("d%0d_resp_result", d), resp_result[d], m_res[d]);
      chk($sformatf("d%0d_resp_ovf", d), resp_overflow[d], m_ovf[d]);
      chk($sformatf("d%0d_resp_unf", d), resp_underflow[d], m_unf[d]);
      chk($sformatf("d%0d_dp_data1", d), dp_data1[d], m_d1[d]);
      chk($sformatf("d%0d_dp_data2", d), dp_data2[d], m_d2[d]);
      acc[d] = rst_pre && !m_busy[d] && fnd[d];
      acc_id[d] = g[d];
      rr_pre[d] = resp_ready[d]; inj_pre[d] = inj[d];
      op_pre[d] = req_op[d]; a_pre[d] = req_a[d]; b_pre[d] = req_b[d];
    end
    @(posedge CLK);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      if (!rst_pre) model_reset(d);
      else if (m_busy[d] && !m_rv[d]) begin
        m_wait[d]--;
        if (m_wait[d] == 0) begin
          r = fp_sub(m_d1[d], m_d2[d]);
          m_res[d] = r[31:0]; m_unf[d] = r[32]; m_ovf[d] = r[33] | inj_pre[d];
          m_rv[d] = 1;
        end
      end else if (m_rv[d]) begin
        if (rr_pre[d]) begin m_rv[d] = 0; m_busy[d] = 0; end
      end else if (fnd[d]) begin
        m_busy[d] = 1; m_wait[d] = lat; m_id[d] = g[d];
        m_ptr[d] = (g[d] + 1) % 2;
        m_d1[d] = a_pre[d][g[d]*32 +: 32];
        bb = b_pre[d][g[d]*32 +: 32];
        if (op_pre[d][g[d]]) bb[31] = ~bb[31];
        m_d2[d] = bb;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_f32();
    logic [7:0] e;
    e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(250, 254)) : 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic new_req(input int d, input int i);
    req_a[d][i*32 +: 32] = rnd_f32();
    req_b[d][i*32 +: 32] = rnd_f32();
    req_op[d][i] = 1'($urandom_range(0, 1));
    req_valid[d][i] = 1'b1;
  endtask

  initial begin
    int ids [$];
    int prev, gi;
    nRST = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_op[d] = 0; req_a[d] = 0; req_b[d] = 0;
      resp_ready[d] = 1'b1; inj[d] = 1'b0;
      model_reset(d);
    end
    repeat (2) @(posedge CLK);
    #1;
    step();
    nRST = 1'b1;

    // 3.0 - 1.0 from requester 0
    req_valid[0] = 2'b01; req_op[0] = 2'b00;
    req_a[0][31:0] = 32'h40400000; req_b[0][31:0] = 32'h3F800000;
    #1;
    chk("t1_ready", req_ready[0], 2'b01);
    step();
    req_valid[0] = 2'b00;
    chk("t1_dp_data1", dp_data1[0], 32'h40400000);
    chk("t1_dp_data2", dp_data2[0], 32'h3F800000);
    chk("t1_rv_early", resp_valid[0], 1'b0);
    step();
    chk("t1_rv", resp_valid[0], 1'b1);
    chk("t1_result", resp_result[0], 32'h40000000);
    chk("t1_id", resp_id[0], 1'b0);
    chk("t1_flags", {resp_overflow[0], resp_underflow[0]}, 2'b00);
    step();

    // 1.0 + 1.0 from requester 1
    req_valid[0] = 2'b10; req_op[0] = 2'b10;
    req_a[0][63:32] = 32'h3F800000; req_b[0][63:32] = 32'h3F800000;
    step();
    req_valid[0] = 2'b00;
    chk("t2_dp_data2", dp_data2[0], 32'hBF800000);
    step();
    chk("t2_result", resp_result[0], 32'h40000000);
    chk("t2_id", resp_id[0], 1'b1);
    step();

    // Both requesters valid from reset: alternate grants, fixed spacing
    new_req(0, 0); new_req(0, 1);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    prev = -1;
    for (int n = 0; n < 60 && ids.size() < 6; n++) begin
      #1;
      chk("t3_not_both", req_ready[0] == 2'b11, 1'b0);
      gi = -1;
      if ((req_ready[0] & req_valid[0]) != 2'b00) begin
        gi = req_ready[0][1] ? 1 : 0;
        if (prev >= 0) chk("t3_gap", 64'(cyc - prev), 64'(3));
        prev = cyc;
      end
      step();
      if (gi >= 0) new_req(0, gi);
      if (resp_valid[0]) ids.push_back(int'(resp_id[0]));
    end
    chk("t3_count", 64'(ids.size()), 64'(6));
    foreach (ids[k]) chk($sformatf("t3_id%0d", k), 64'(ids[k]), 64'(k % 2));
    req_valid[0] = 2'b00;
    repeat (3) step();

    // Backpressure: response held while a second request waits
    resp_ready[0] = 1'b0;
    new_req(0, 0); new_req(0, 1);
    step();
    req_valid[0][0] = 1'b0;
    for (int n = 0; n < 10 && !resp_valid[0]; n++) step();
    chk("t4_rv_rise", resp_valid[0], 1'b1);
    repeat (5) begin
      chk("t4_no_ready", req_ready[0], 2'b00);
      chk("t4_rv_held", resp_valid[0], 1'b1);
      step();
    end
    resp_ready[0] = 1'b1;
    step();
    chk("t4_idle_grant", req_ready[0], 2'b10);
    step();
    chk("t4_next_op", dp_data1[0], req_a[0][63:32]);
    req_valid[0] = 2'b00;
    repeat (3) step();

    // Latency-3 instance: reset during the second EXEC cycle drops the op
    new_req(1, 0); new_req(1, 1);
    step();
    step();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("t5_rv", resp_valid[1], 1'b0);
    chk("t5_grant0", req_ready[1], 2'b01);
    chk("t5_dp_data1", dp_data1[1], 32'd0);
    chk("t5_result", resp_result[1], 32'd0);
    step();
    req_valid[1] = 2'b00;
    repeat (6) step();

    // Overflow asserted by the datapath only in the sampling cycle
    resp_ready[0] = 1'b0;
    req_valid[0] = 2'b01; req_op[0] = 2'b00;
    req_a[0][31:0] = 32'h41200000; req_b[0][31:0] = 32'h40000000;
    step();
    req_valid[0] = 2'b00;
    inj[0] = 1'b1;
    step();
    inj[0] = 1'b0;
    repeat (3) begin
      chk("t6_ovf_held", resp_overflow[0], 1'b1);
      step();
    end
    resp_ready[0] = 1'b1;
    step();
    chk("t6_released", resp_valid[0], 1'b0);

    // Random traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 2; i++) begin
          if (acc[d] && acc_id[d] == i) begin
            if ($urandom_range(0, 1) == 0) new_req(d, i);
            else req_valid[d][i] = 1'b0;
          end else if (!req_valid[d][i]) begin
            if ($urandom_range(0, 2) == 0) new_req(d, i);
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid[d][i] = 1'b0;
          end
        end
        resp_ready[d] = ($urandom_range(0, 3) != 0);
      end
      nRST = ($urandom_range(0, 199) != 0);
    end
    nRST = 1'b1;
    req_valid[0] = 2'b00; req_valid[1] = 2'b00;
    resp_ready[0] = 1'b1; resp_ready[1] = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_sub_arbiter.md
Name: fpu_sub_arbiter

Overview:
Shares one combinational FP32 subtraction datapath (data1 − data2 → result, overflow, underflow) between NREQ requesters. Round-robin arbitration, valid/ready handshake on both request and response sides. Add requests are turned into subtractions by flipping the sign bit of operand B. Operands are registered toward the datapath, held stable for DP_LATENCY cycles, then sampled into a response register.

Parameters:
NREQ, 2, number of requesters (≥2)
WIDTH, 32, operand/result width (IEEE-754 single; sign bit = WIDTH-1)
DP_LATENCY, 1, cycles operands are held on the datapath before sampling (≥1)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_op  in  NREQ  per-requester op: 0 = A−B, 1 = A+B
req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  clog2(NREQ)  index of requester the response belongs to
resp_result  out  WIDTH  sampled dp_result
resp_overflow  out  1  sampled dp_overflow
resp_underflow  out  1  sampled dp_underflow
dp_data1  out  WIDTH  to datapath data1 (registered)
dp_data2  out  WIDTH  to datapath data2 (registered)
dp_result  in  WIDTH  from datapath result
dp_overflow  in  1  from datapath overflow
dp_underflow  in  1  from datapath underflow

Behaviour:
- Reset (nRST=0 at an edge, in any state): state=IDLE, rr_ptr=0, cnt=0, resp_valid=0, resp_id=0, resp_result=0, resp_overflow=0, resp_underflow=0, dp_data1=0, dp_data2=0. The in-flight op is dropped with no response.
- States: IDLE, EXEC, RESP.
- Grant (combinational, IDLE only): the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ. req_ready[i]=1 only for the granted i while in IDLE; req_ready=0 in EXEC/RESP. At most one bit set.
- Accept (IDLE, req_valid[g]&req_ready[g] at an edge):
  - dp_data1←a[g].
  - dp_data2←b[g] when op=0; b[g] with bit WIDTH-1 inverted when op=1.
  - resp_id←g; rr_ptr←(g+1) mod NREQ; cnt←DP_LATENCY-1; state→EXEC.
- EXEC: dp_data* held. Each edge with cnt≠0: cnt←cnt-1. Edge with cnt=0: resp_result/overflow/underflow←dp_*; resp_valid←1; state→RESP.
- Timing: resp_valid rises DP_LATENCY edges after the accept edge. With DP_LATENCY=1, accept at edge N gives resp_valid high after edge N+1.
- RESP: resp_* held stable while resp_valid=1 && resp_ready=0. On the edge with resp_ready=1: resp_valid←0, state→IDLE.
- No new request is accepted in the same cycle as the response handshake. Max throughput is one op per DP_LATENCY+2 cycles.
- dp_data1/dp_data2 keep their last operands after completion (not cleared).
- Requesters must hold req_a/req_b/req_op stable while req_valid=1 && req_ready=0. req_valid may drop before grant without error.
- resp_ready high before resp_valid is legal and has no effect.
- No NaN/Inf/denormal inspection: flags and result pass through unmodified, including the sign-flipped NaN when op=1.
- cnt width: clog2(DP_LATENCY+1), minimum 1.

Test Plan:
1. DP_LATENCY=1, real subtraction datapath, resp_ready=1; req0: a=0x40400000, b=0x3F800000, op=0 → req_ready=2'b01 in accept cycle; next cycle dp_data1=0x40400000, dp_data2=0x3F800000; resp_valid=1 one cycle later with resp_result=0x40000000, resp_id=0, flags=0.
2. req1 only: a=0x3F800000, b=0x3F800000, op=1 → dp_data2=0xBF800000, resp_result=0x40000000, resp_id=1.
3. Both req_valid held high from reset, resp_ready=1, 6 ops → resp_id sequence 0,1,0,1,0,1; req_ready never 2'b11; accept edges exactly DP_LATENCY+2 cycles apart.
4. Backpressure: resp_ready=0 for 5 cycles after resp_valid rises → resp_valid, resp_result and resp_id stable; req_ready=0 throughout; on resp_ready=1, IDLE next cycle and the pending request is accepted the cycle after.
5. DP_LATENCY=3; assert nRST=0 for one edge in the 2nd EXEC cycle → resp_valid never rises for that op; all outputs at reset values; rr_ptr=0, so with both valid, the next grant goes to req0.
6. Stub datapath drives dp_overflow=1 and dp_underflow=0 only during the sampling cycle (0 otherwise) → resp_overflow=1 captured and held through RESP until the handshake.
